inst_fetch: RTL

- Instruction fetch unit for the RV32I core; it is the producer side of the fetch-to-decode interface.
- Reads each 32-bit instruction from the byte-wide unified memory port as four little-endian byte reads.
- Presents the instruction and its PC to the decoder with a valid/stall handshake.
- Accepts redirect/flush requests (decFlush, dec2if) from the decoder.

---
 rtl/inst_fetch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: assembles 32-bit instructions from four little-endian
// byte reads and hands them to decode over a valid/stall handshake with redirect.
module inst_fetch #(
    parameter int unsigned                ADDR_WIDTH = 32,
    parameter int unsigned                INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_din,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_rd_en,
    output logic                  if2dec,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [INST_WIDTH-1:0] inst_in,
    input  logic                  dec_stall,
    input  logic                  decFlush,
    input  logic [ADDR_WIDTH-1:0] dec2if
);

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned BUF_W   = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [BUF_W-1:0]        buf_q, buf_d;
    logic                    if2dec_q, if2dec_d;
    logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q  <= FETCH;
            cnt_q    <= '0;
            pc_q     <= RESET_PC;
            buf_q    <= '0;
            if2dec_q <= 1'b0;
            pc_out_q <= '0;
            inst_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            if2dec_q <= if2dec_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
        end
    end

    // Next-state logic; memory request decoded straight from the current state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        if2dec_d  = if2dec_q;
        pc_out_d  = pc_out_q;
        inst_d    = inst_q;
        mem_rd_en = 1'b0;
        mem_a     = '0;

        if (!rst_in && (state_q == FETCH) && (cnt_q < CNT_LAST)) begin
            mem_rd_en = 1'b1;
            mem_a     = pc_q + ADDR_WIDTH'(cnt_q);
        end

        if (rdy_in) begin
            if (decFlush) begin
                // Flush beats any transfer or fetch progress in the same cycle
                pc_d     = dec2if & ~ADDR_WIDTH'(3);
                if2dec_d = 1'b0;
                state_d  = FETCH;
                cnt_d    = '0;
            end else begin
                case (state_q)
                    FETCH: begin
                        case (cnt_q)
                            CNT_W'(1): buf_d[7:0]   = mem_din;
                            CNT_W'(2): buf_d[15:8]  = mem_din;
                            CNT_W'(3): buf_d[23:16] = mem_din;
                            default: ;
                        endcase
                        if (cnt_q >= CNT_LAST) begin
                            inst_d   = INST_WIDTH'({mem_din, buf_q});
                            pc_out_d = pc_q;
                            if2dec_d = 1'b1;
                            state_d  = VALID;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    VALID: begin
                        if (!dec_stall) begin
                            pc_d     = pc_q + ADDR_WIDTH'(4);
                            if2dec_d = 1'b0;
                            state_d  = FETCH;
                            cnt_d    = '0;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
        end
    end

    assign if2dec  = if2dec_q;
    assign pc_out  = pc_out_q;
    assign inst_in = inst_q;

endmodule
